// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, the
// architectural zero register and the grouped pipeline-register controls.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic exmem_flush;
    logic memwb_we;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{
    ifid_we: 1'b1, ifid_flush: 1'b0,
    idex_we: 1'b1, idex_flush: 1'b0,
    exmem_we: 1'b1, exmem_flush: 1'b0,
    memwb_we: 1'b1, memwb_flush: 1'b0
  };

  // Memory stall: everything up to EX/MEM holds, a bubble drains into MEM/WB.
  localparam ctrl_t CTRL_FROZEN = '{
    ifid_we: 1'b0, ifid_flush: 1'b0,
    idex_we: 1'b0, idex_flush: 1'b0,
    exmem_we: 1'b0, exmem_flush: 1'b0,
    memwb_we: 1'b0, memwb_flush: 1'b1
  };

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller: hazard
// sources flow in, register enables and flushes flow out.
interface pipe_hazard_ctrl_if;

  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_uses_rt_i;
  logic       ex_memread_i;
  logic [4:0] ex_rt_i;
  logic       branch_taken_mem_i;
  logic       jump_mem_i;
  logic       dm_req_i;
  logic       dm_ready_i;

  logic       pc_we_o;
  logic       ifid_we_o;
  logic       idex_we_o;
  logic       exmem_we_o;
  logic       memwb_we_o;
  logic       ifid_flush_o;
  logic       idex_flush_o;
  logic       exmem_flush_o;
  logic       memwb_flush_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
           branch_taken_mem_i, jump_mem_i, dm_req_i, dm_ready_i,
    input  pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
           branch_taken_mem_i, jump_mem_i, dm_req_i, dm_ready_i,
    output pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and redirect performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational controls from
// the hazard terms and FSM state, plus a sticky memory-timeout halt.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave hz,
  output logic [1:0]       state_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WC_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(WAIT_LIMIT);

  state_e          state_q;
  logic [WC_W-1:0] wait_cnt_q;
  logic            halt_q;

  logic  load_use;
  logic  redirect;
  logic  mem_busy;
  ctrl_t ctrl;
  logic  pc_we;
  logic  flush_evt;

  // Register zero never carries a real dependency, so it cannot cause a stall.
  assign load_use = hz.ex_memread_i && (hz.ex_rt_i != REG_ZERO) &&
                    ((hz.ex_rt_i == hz.id_rs_i) ||
                     (hz.id_uses_rt_i && (hz.ex_rt_i == hz.id_rt_i)));
  assign redirect = hz.branch_taken_mem_i || hz.jump_mem_i;
  assign mem_busy = hz.dm_req_i && !hz.dm_ready_i;

  always_comb begin
    ctrl      = CTRL_NORMAL;
    pc_we     = 1'b1;
    flush_evt = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          ctrl  = CTRL_FROZEN;
          pc_we = 1'b0;
        end else if (redirect) begin
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_flush  = 1'b1;
          ctrl.exmem_flush = 1'b1;
          flush_evt        = 1'b1;
        end else if (load_use) begin
          pc_we           = 1'b0;
          ctrl.ifid_we    = 1'b0;
          ctrl.idex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.dm_ready_i) begin
          ctrl  = CTRL_FROZEN;
          pc_we = 1'b0;
        end
      end
      HALT: begin
        ctrl  = CTRL_IDLE;
        pc_we = 1'b0;
      end
      default: begin
        ctrl  = CTRL_NORMAL;
        pc_we = 1'b1;
      end
    endcase
    if (!rst_n) begin
      ctrl      = CTRL_IDLE;
      pc_we     = 1'b0;
      flush_evt = 1'b0;
    end
  end

  // A ready on the limit cycle still wins; only a missing ready there halts.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      halt_q     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (hz.dm_ready_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q >= WAIT_MAX) begin
            state_q <= HALT;
            halt_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end
        HALT: begin
          halt_q <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (!pc_we),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (flush_evt),
    .cnt_o (flush_cnt_o)
  );

  assign hz.pc_we_o       = pc_we;
  assign hz.ifid_we_o     = ctrl.ifid_we;
  assign hz.idex_we_o     = ctrl.idex_we;
  assign hz.exmem_we_o    = ctrl.exmem_we;
  assign hz.memwb_we_o    = ctrl.memwb_we;
  assign hz.ifid_flush_o  = ctrl.ifid_flush;
  assign hz.idex_flush_o  = ctrl.idex_flush;
  assign hz.exmem_flush_o = ctrl.exmem_flush;
  assign hz.memwb_flush_o = ctrl.memwb_flush;

  assign state_o = state_q;
  assign halt_o  = halt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short wait limit and 2-bit
// counters so timeout and saturation are reachable in a few cycles.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] NORMAL   = 9'b11111_0000;
  localparam logic [8:0] LOADUSE  = 9'b00111_0100;
  localparam logic [8:0] REDIRECT = 9'b11111_1110;
  localparam logic [8:0] FROZEN   = 9'b00000_0001;
  localparam logic [8:0] ALLZERO  = 9'b00000_0000;

  logic       clk_i;
  logic       rst_n;
  logic [1:0] state_o;
  logic       halt_o;
  logic [1:0] stall_cnt_o;
  logic [1:0] flush_cnt_o;
  logic [8:0] ctrlVec;
  int         checks;
  int         errors;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.WAIT_LIMIT(4), .CNT_W(2)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .hz          (bus),
    .state_o     (state_o),
    .halt_o      (halt_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  // {pc, ifid, idex, exmem, memwb} enables then {ifid, idex, exmem, memwb} flushes
  assign ctrlVec = {bus.pc_we_o, bus.ifid_we_o, bus.idex_we_o, bus.exmem_we_o,
                    bus.memwb_we_o, bus.ifid_flush_o, bus.idex_flush_o,
                    bus.exmem_flush_o, bus.memwb_flush_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic idle();
    bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0; bus.id_uses_rt_i = 1'b0;
    bus.ex_memread_i = 1'b0; bus.ex_rt_i = 5'd0;
    bus.branch_taken_mem_i = 1'b0; bus.jump_mem_i = 1'b0;
    bus.dm_req_i = 1'b0; bus.dm_ready_i = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk_i); idle(); rst_n = 1'b0;
    @(negedge clk_i); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0; #1;
    checks++; if (ctrlVec !== ALLZERO) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrlVec, ALLZERO); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (halt_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got %b expected 0", halt_o); end
    checks++; if ({stall_cnt_o, flush_cnt_o} !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnts: got %b expected 0000", {stall_cnt_o, flush_cnt_o}); end
    @(negedge clk_i); rst_n = 1'b1; #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL post_reset_ctrl: got %b expected %b", ctrlVec, NORMAL); end
  endtask

  task automatic test_load_use();
    doReset();
    bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd8; bus.id_rs_i = 5'd8; #1;
    checks++; if (ctrlVec !== LOADUSE) begin errors++; $display("[TB] FAIL lu_rs_ctrl: got %b expected %b", ctrlVec, LOADUSE); end
    @(negedge clk_i); bus.ex_memread_i = 1'b0; #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL lu_release_ctrl: got %b expected %b", ctrlVec, NORMAL); end
    checks++; if (stall_cnt_o !== 2'd1) begin errors++; $display("[TB] FAIL lu_stall_cnt: got %0d expected 1", stall_cnt_o); end
    @(negedge clk_i);
    bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd8; bus.id_rs_i = 5'd3;
    bus.id_rt_i = 5'd8; bus.id_uses_rt_i = 1'b1; #1;
    checks++; if (ctrlVec !== LOADUSE) begin errors++; $display("[TB] FAIL lu_rt_ctrl: got %b expected %b", ctrlVec, LOADUSE); end
    @(negedge clk_i); bus.id_uses_rt_i = 1'b0; #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL lu_rt_unused_ctrl: got %b expected %b", ctrlVec, NORMAL); end
    checks++; if (stall_cnt_o !== 2'd2) begin errors++; $display("[TB] FAIL lu_stall_cnt2: got %0d expected 2", stall_cnt_o); end
    @(negedge clk_i);
    bus.ex_rt_i = 5'd0; bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0; bus.id_uses_rt_i = 1'b1; #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL reg_zero_ctrl: got %b expected %b", ctrlVec, NORMAL); end
    @(negedge clk_i); idle(); #1;
    checks++; if (stall_cnt_o !== 2'd2) begin errors++; $display("[TB] FAIL reg_zero_stall_cnt: got %0d expected 2", stall_cnt_o); end
  endtask

  task automatic test_redirect();
    doReset();
    bus.branch_taken_mem_i = 1'b1; #1;
    checks++; if (ctrlVec !== REDIRECT) begin errors++; $display("[TB] FAIL branch_ctrl: got %b expected %b", ctrlVec, REDIRECT); end
    @(negedge clk_i); bus.branch_taken_mem_i = 1'b0; bus.jump_mem_i = 1'b1; #1;
    checks++; if (ctrlVec !== REDIRECT) begin errors++; $display("[TB] FAIL jump_ctrl: got %b expected %b", ctrlVec, REDIRECT); end
    checks++; if (flush_cnt_o !== 2'd1) begin errors++; $display("[TB] FAIL branch_flush_cnt: got %0d expected 1", flush_cnt_o); end
    @(negedge clk_i);
    bus.jump_mem_i = 1'b0; bus.branch_taken_mem_i = 1'b1;
    bus.ex_memread_i = 1'b1; bus.ex_rt_i = 5'd9; bus.id_rs_i = 5'd9; #1;
    checks++; if (ctrlVec !== REDIRECT) begin errors++; $display("[TB] FAIL redirect_over_lu_ctrl: got %b expected %b", ctrlVec, REDIRECT); end
    @(negedge clk_i); idle(); #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL redirect_done_ctrl: got %b expected %b", ctrlVec, NORMAL); end
    checks++; if (flush_cnt_o !== 2'd3) begin errors++; $display("[TB] FAIL redirect_flush_cnt: got %0d expected 3", flush_cnt_o); end
    checks++; if (stall_cnt_o !== 2'd0) begin errors++; $display("[TB] FAIL redirect_stall_cnt: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_mem_wait();
    doReset();
    for (int i = 0; i < 3; i++) begin
      bus.dm_req_i = 1'b1; bus.dm_ready_i = 1'b0; bus.branch_taken_mem_i = 1'b1; #1;
      checks++; if (ctrlVec !== FROZEN) begin errors++; $display("[TB] FAIL memwait_ctrl[%0d]: got %b expected %b", i, ctrlVec, FROZEN); end
      checks++; if (state_o !== ((i == 0) ? 2'd0 : 2'd1)) begin errors++; $display("[TB] FAIL memwait_state[%0d]: got %0d expected %0d", i, state_o, (i == 0) ? 0 : 1); end
      @(negedge clk_i);
    end
    bus.dm_ready_i = 1'b1; #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL memwait_ready_ctrl: got %b expected %b", ctrlVec, NORMAL); end
    checks++; if (state_o !== 2'd1) begin errors++; $display("[TB] FAIL memwait_ready_state: got %0d expected 1", state_o); end
    checks++; if (stall_cnt_o !== 2'd3) begin errors++; $display("[TB] FAIL memwait_stall_cnt: got %0d expected 3", stall_cnt_o); end
    @(negedge clk_i); bus.dm_req_i = 1'b0; bus.dm_ready_i = 1'b0; #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL memwait_back_state: got %0d expected 0", state_o); end
    checks++; if (ctrlVec !== REDIRECT) begin errors++; $display("[TB] FAIL memwait_then_branch_ctrl: got %b expected %b", ctrlVec, REDIRECT); end
    checks++; if (flush_cnt_o !== 2'd0) begin errors++; $display("[TB] FAIL memwait_flush_cnt0: got %0d expected 0", flush_cnt_o); end
    @(negedge clk_i); idle(); #1;
    checks++; if (flush_cnt_o !== 2'd1) begin errors++; $display("[TB] FAIL memwait_flush_cnt1: got %0d expected 1", flush_cnt_o); end
  endtask

  task automatic test_back_to_back();
    doReset();
    bus.dm_req_i = 1'b1; bus.dm_ready_i = 1'b1; #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL ready_same_cycle_ctrl: got %b expected %b", ctrlVec, NORMAL); end
    @(negedge clk_i); idle(); #1;
    checks++; if (state_o !== 2'd0) begin errors++; $display("[TB] FAIL ready_same_cycle_state: got %0d expected 0", state_o); end
    checks++; if (stall_cnt_o !== 2'd0) begin errors++; $display("[TB] FAIL ready_same_cycle_stall: got %0d expected 0", stall_cnt_o); end
  endtask

  task automatic test_timeout();
    doReset();
    bus.dm_req_i = 1'b1; bus.dm_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ctrlVec !== FROZEN) begin errors++; $display("[TB] FAIL timeout_ctrl[%0d]: got %b expected %b", i, ctrlVec, FROZEN); end
      checks++; if (state_o !== ((i == 0) ? 2'd0 : 2'd1)) begin errors++; $display("[TB] FAIL timeout_state[%0d]: got %0d expected %0d", i, state_o, (i == 0) ? 0 : 1); end
      @(negedge clk_i);
    end
    #1;
    checks++; if (state_o !== 2'd2) begin errors++; $display("[TB] FAIL halt_state: got %0d expected 2", state_o); end
    checks++; if (halt_o !== 1'b1) begin errors++; $display("[TB] FAIL halt_flag: got %b expected 1", halt_o); end
    checks++; if (ctrlVec !== ALLZERO) begin errors++; $display("[TB] FAIL halt_ctrl: got %b expected %b", ctrlVec, ALLZERO); end
    @(negedge clk_i); bus.dm_ready_i = 1'b1; @(negedge clk_i); #1;
    checks++; if ({halt_o, state_o} !== 3'b110) begin errors++; $display("[TB] FAIL halt_sticky: got %b expected 110", {halt_o, state_o}); end
    checks++; if (stall_cnt_o !== 2'd3) begin errors++; $display("[TB] FAIL halt_stall_sat: got %0d expected 3", stall_cnt_o); end
    #2; rst_n = 1'b0; #1;
    checks++; if ({halt_o, state_o} !== 3'b000) begin errors++; $display("[TB] FAIL async_reset_state: got %b expected 000", {halt_o, state_o}); end
    checks++; if ({stall_cnt_o, flush_cnt_o} !== 4'd0) begin errors++; $display("[TB] FAIL async_reset_cnts: got %b expected 0000", {stall_cnt_o, flush_cnt_o}); end
    @(negedge clk_i); idle(); rst_n = 1'b1; #1;
    checks++; if (ctrlVec !== NORMAL) begin errors++; $display("[TB] FAIL after_halt_ctrl: got %b expected %b", ctrlVec, NORMAL); end
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 5; i++) begin
      bus.branch_taken_mem_i = 1'b1; #1;
      checks++; if (flush_cnt_o !== ((i < 3) ? 2'(i) : 2'd3)) begin errors++; $display("[TB] FAIL sat_flush_cnt[%0d]: got %0d expected %0d", i, flush_cnt_o, (i < 3) ? i : 3); end
      @(negedge clk_i);
    end
    idle(); #1;
    checks++; if (flush_cnt_o !== 2'd3) begin errors++; $display("[TB] FAIL sat_flush_final: got %0d expected 3", flush_cnt_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline CPU. Each cycle it produces the write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Three conditions drive it:
- load-use hazards seen in ID;
- taken branches and jumps resolved at the EX/MEM register outputs;
- multi-cycle data-memory accesses signalled by a ready handshake.

It also keeps saturating performance counters and a sticky memory-timeout halt.

## Interface
Parameters:
- WAIT_LIMIT, 255, max consecutive MEM_WAIT cycles before halting
- CNT_W, 16, width of performance counters

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_rs_i  in  5  rs field of instruction in ID
- id_rt_i  in  5  rt field of instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt as a source
- ex_memread_i  in  1  ID/EX holds a load
- ex_rt_i  in  5  destination rt of that load
- branch_taken_mem_i  in  1  EX/MEM branch with condition true
- jump_mem_i  in  1  EX/MEM jump
- dm_req_i  in  1  EX/MEM instruction accesses data memory
- dm_ready_i  in  1  data memory completes this cycle
- pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o  out  1 each  register enables
- ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o  out  1 each  load a bubble (all-zero) into that register
- state_o  out  2  FSM state: RUN=0, MEM_WAIT=1, HALT=2
- halt_o  out  1  sticky timeout indicator
- stall_cnt_o  out  CNT_W  cycles with pc_we_o=0, saturating
- flush_cnt_o  out  CNT_W  redirect events, saturating

## Operation
Control outputs are combinational from the current state and inputs. The FSM, counters and halt are registered.

Input terms:
- load_use = ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i))
- redirect = branch_taken_mem_i || jump_mem_i
- mem_busy = dm_req_i && !dm_ready_i

Priority in RUN is mem_busy > redirect > load_use > normal.
- Normal: all *_we_o=1, all *_flush_o=0.
- load_use:
  - pc_we_o=0, ifid_we_o=0 (PC and IF/ID hold);
  - idex_flush_o=1 (bubble into ID/EX);
  - exmem_we_o=1, memwb_we_o=1.
- redirect:
  - all enables=1; the PC loads the target;
  - ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1;
  - flush_cnt_o increments.
- mem_busy:
  - all enables=0 (PC through EX/MEM frozen);
  - memwb_flush_o=1;
  - next state MEM_WAIT with wait_cnt=1.

MEM_WAIT:
- Outputs are the same as mem_busy.
- When dm_ready_i=1, outputs are the normal set and the next state is RUN. The frozen instruction advances, and redirect and load_use are re-evaluated next cycle in RUN.
- Otherwise wait_cnt increments. When wait_cnt reaches WAIT_LIMIT with dm_ready_i still 0, the next state is HALT.

HALT:
- All enables=0, all flushes=0, halt_o=1.
- Left only by reset.

Counters:
- stall_cnt_o increments on every cycle with pc_we_o=0 (load_use, MEM_WAIT, the mem_busy entry cycle, HALT).
- Both counters saturate at 2^CNT_W-1.

## Timing
- While rst_n=0: state RUN, wait_cnt=0, halt_o=0, both counters 0, all enables and flushes forced to 0.
- After reset release with idle inputs: enables=1, flushes=0.
- Latency of control response: zero cycles (same cycle as the input condition).
- Load-use costs exactly one bubble. Next cycle the load is in EX/MEM, so load_use deasserts without FSM involvement.
- Redirect costs three flushed slots.
- mem_busy with ready after N cycles costs N frozen cycles. dm_ready_i on the same cycle as dm_req_i costs nothing.
- Load-use together with redirect: redirect wins, and the ID instruction is flushed anyway.
- Reset asserted in MEM_WAIT or HALT returns to RUN asynchronously.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding (RUN/MEM_WAIT/HALT);
  - the register-0 constant;
  - the ctrl struct grouping the four enable/flush pairs.
- One sub-module, sat_counter (width parameter, inc, clear on reset), instantiated for stall_cnt_o and flush_cnt_o.
- The hazard comparators stay inline.

## Test plan
- Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 -> one cycle of pc_we_o=0, ifid_we_o=0, idex_flush_o=1; stall_cnt_o=1.
- Register zero: ex_rt_i=0, id_rs_i=0, ex_memread_i=1 -> no stall.
- Branch: branch_taken_mem_i=1 for 1 cycle -> ifid/idex/exmem flushes=1; flush_cnt_o=1.
- Memory wait: dm_req_i=1, dm_ready_i low for 3 cycles -> enables 0 and memwb_flush_o=1 for 3 cycles, state_o=1, then RUN; stall_cnt_o=3.
- Timeout: WAIT_LIMIT=4, dm_ready_i held 0 -> state_o=2, halt_o=1 after 4 cycles, held until rst_n pulse, which clears everything.
- Counter saturation: CNT_W=2 with 5 redirects -> flush_cnt_o=3.
